// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared opcode/funct constants, FSM state enum and instruction field widths
package datapath_pkg;

    localparam int INSTR_W = 16;
    localparam int OP_W    = 3;
    localparam int REG_W   = 3;
    localparam int IMM_W   = 7;
    localparam int FUNCT_W = 3;
    localparam int NUM_REGS = 8;

    localparam logic [OP_W-1:0] OP_RTYPE = 3'b000;
    localparam logic [OP_W-1:0] OP_ADDI  = 3'b001;
    localparam logic [OP_W-1:0] OP_LW    = 3'b010;
    localparam logic [OP_W-1:0] OP_SW    = 3'b011;
    localparam logic [OP_W-1:0] OP_BEQ   = 3'b100;
    localparam logic [OP_W-1:0] OP_JMP   = 3'b101;
    localparam logic [OP_W-1:0] OP_NOP   = 3'b110;
    localparam logic [OP_W-1:0] OP_HALT  = 3'b111;

    localparam logic [FUNCT_W-1:0] FN_ADD = 3'b000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 3'b001;
    localparam logic [FUNCT_W-1:0] FN_AND = 3'b010;
    localparam logic [FUNCT_W-1:0] FN_OR  = 3'b011;
    localparam logic [FUNCT_W-1:0] FN_XOR = 3'b100;
    localparam logic [FUNCT_W-1:0] FN_SLT = 3'b101;
    localparam logic [FUNCT_W-1:0] FN_SLL = 3'b110;
    localparam logic [FUNCT_W-1:0] FN_SRL = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 8 x DATA_W register file, r0 hardwired to zero, two async reads, one sync write
module reg_file
    import datapath_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [REG_W-1:0]  raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [REG_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Clear all registers on reset; drop writes that target r0 so it stays zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/multi_cycle_datapath.sv
// rtl/multi_cycle_datapath.sv - multi-cycle 16-bit-ISA core; BEQ/JMP enabled by DATAPATH_BRANCH_EN
module multi_cycle_datapath
    import datapath_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic               CLK,
    input  logic               RESET,
    output logic               imem_req,
    output logic [DATA_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ack,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DATA_W-1:0]  dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_ack,
    output logic [DATA_W-1:0]  PC,
    output logic               halted
);

    localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(1);

    state_t              state;
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   pc_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   result_q;
    logic [DATA_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic [OP_W-1:0]     op;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [IMM_W-1:0]    imm;
    logic [FUNCT_W-1:0]  funct;
    logic [DATA_W-1:0]   imm_sext;

    logic [REG_W-1:0]    rf_raddr_b;
    logic [DATA_W-1:0]   rf_rdata_a;
    logic [DATA_W-1:0]   rf_rdata_b;
    logic                rf_we;

    logic [FUNCT_W-1:0]  alu_fn;
    logic [DATA_W-1:0]   alu_b;
    logic [DATA_W-1:0]   alu_out;
    logic [DATA_W-1:0]   pc_plus1;
    logic [DATA_W-1:0]   pc_target;
    logic                branch_taken;

    assign op       = ir[15:13];
    assign rd       = ir[12:10];
    assign rs       = ir[9:7];
    assign imm      = ir[6:0];
    assign rt       = imm[6:4];
    assign funct    = imm[2:0];
    assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

    // Port B carries rt for R-type and rd otherwise (BEQ compare, SW store data).
    assign rf_raddr_b = (op == OP_RTYPE) ? rt : rd;
    assign rf_we      = (state == S_WB);

    assign pc_plus1  = pc_q + PC_STEP;
    assign pc_target = pc_plus1 + imm_sext;

    assign imem_addr  = pc_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign PC         = pc_q;

    reg_file #(
        .DATA_W (DATA_W)
    ) u_reg_file (
        .clk     (CLK),
        .reset   (RESET),
        .raddr_a (rs),
        .rdata_a (rf_rdata_a),
        .raddr_b (rf_raddr_b),
        .rdata_b (rf_rdata_b),
        .we      (rf_we),
        .waddr   (rd),
        .wdata   (result_q)
    );

    // ALU: ADDI reuses the adder with the sign-extended immediate as second operand.
    always_comb begin
        alu_fn  = (op == OP_RTYPE) ? funct : FN_ADD;
        alu_b   = (op == OP_RTYPE) ? b_q : imm_sext;
        alu_out = '0;
        case (alu_fn)
            FN_ADD: alu_out = a_q + alu_b;
            FN_SUB: alu_out = a_q - alu_b;
            FN_AND: alu_out = a_q & alu_b;
            FN_OR:  alu_out = a_q | alu_b;
            FN_XOR: alu_out = a_q ^ alu_b;
            FN_SLT: alu_out = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(alu_b))};
            FN_SLL: alu_out = {a_q[DATA_W-2:0], 1'b0};
            FN_SRL: alu_out = {1'b0, a_q[DATA_W-1:1]};
            default: alu_out = '0;
        endcase
    end

    // Branch decision; without the branch feature BEQ/JMP fall through like NOP.
    always_comb begin
        branch_taken = 1'b0;
`ifdef DATAPATH_BRANCH_EN
        if (op == OP_BEQ) begin
            branch_taken = (b_q == a_q);
        end else if (op == OP_JMP) begin
            branch_taken = 1'b1;
        end
`endif
    end

    // Main control FSM; all bus requests and status outputs are registered here.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_FETCH;
            pc_q     <= RESET_PC;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            halted   <= 1'b0;
            ir       <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    // Ack only counts once our request is actually on the bus.
                    if (imem_req && imem_ack) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                S_DECODE: begin
                    a_q   <= rf_rdata_a;
                    b_q   <= rf_rdata_b;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    case (op)
                        OP_RTYPE, OP_ADDI: begin
                            result_q <= alu_out;
                            state    <= S_WB;
                        end
                        OP_LW, OP_SW: begin
                            addr_q   <= a_q + imm_sext;
                            wdata_q  <= b_q;
                            dmem_req <= 1'b1;
                            dmem_we  <= (op == OP_SW);
                            state    <= S_MEM;
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                        default: begin
                            pc_q     <= branch_taken ? pc_target : pc_plus1;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem_req && dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (dmem_we) begin
                            pc_q     <= pc_plus1;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end else begin
                            result_q <= dmem_rdata;
                            state    <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    pc_q     <= pc_plus1;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule
